// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: waveform mode codes,
// midscale helper and configuration reset defaults.
package dds_pkg;

  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SAW    = 2'd3;

  localparam logic [1:0] RST_MODE = MODE_SINE;

  // Offset-binary midscale for a sample of width w.
  function automatic int unsigned mid(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // Reset duty threshold: midscale, i.e. 50 % square.
  function automatic int unsigned rst_duty(input int unsigned w);
    return mid(w);
  endfunction

  // Reset amplitude: full scale (all ones).
  function automatic int unsigned rst_amp(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/dds_amp_scale.sv
// Stage 3 of the DDS pipeline: centre the raw sample, scale it by amp with
// floor arithmetic shift, and re-add midscale. Registered outputs.
module dds_amp_scale
  import dds_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AMP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] raw,
  input  logic [AMP_W-1:0]  amp,
  input  logic              wrap,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              sync
);

  localparam int unsigned       PROD_W = DATA_W + AMP_W + 2;
  localparam logic [DATA_W-1:0] MID_V  = DATA_W'(mid(DATA_W));

  logic signed [DATA_W:0]   diff_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] scaled_c;

  // Signed product keeps the floor behaviour of >>> for negative samples.
  always_comb begin
    diff_c   = $signed({1'b0, raw}) - $signed({1'b0, MID_V});
    prod_c   = PROD_W'(diff_c) * PROD_W'($signed({1'b0, amp}));
    scaled_c = (prod_c >>> AMP_W) + PROD_W'($signed({1'b0, MID_V}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= MID_V;
      value_valid <= 1'b0;
      sync        <= 1'b0;
    end else begin
      value_valid <= valid;
      sync        <= valid & wrap;
      if (valid) begin
        value <= DATA_W'(scaled_c);
      end
    end
  end

endmodule

// File: rtl/dds_wave_gen.sv
// Multi-waveform DDS core: phase accumulator with shadowed config, sine ROM
// addressing, ROM-latency-aligned waveform select and amplitude scaling.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned AMP_W   = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic               phase_clr,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic [PHASE_W-1:0] cfg_offset,
  input  logic [DATA_W-1:0]  cfg_duty,
  input  logic [AMP_W-1:0]   cfg_amp,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_q,
  output logic [DATA_W-1:0]  dac_value,
  output logic               dac_valid,
  output logic               sync_out
);

  localparam logic [DATA_W-1:0] MID_V   = DATA_W'(mid(DATA_W));
  localparam logic [DATA_W-1:0] DUTY_RST = DATA_W'(rst_duty(DATA_W));
  localparam logic [AMP_W-1:0]  AMP_RST = AMP_W'(rst_amp(AMP_W));
  localparam logic [DATA_W-1:0] FULL_V  = '1;

  // Config fields consumed after stage 0 (fcw is consumed at stage 0 directly).
  typedef struct packed {
    logic [PHASE_W-1:0] offset;
    logic [1:0]         mode;
    logic [DATA_W-1:0]  duty;
    logic [AMP_W-1:0]   amp;
  } act_t;

  typedef struct packed {
    logic              valid;
    logic              wrap;
    logic [1:0]        mode;
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] duty;
    logic [AMP_W-1:0]  amp;
  } pipe_t;

  localparam act_t ACT_RST = '{offset: '0, mode: RST_MODE, duty: DUTY_RST, amp: AMP_RST};

  logic [PHASE_W-1:0] sh_fcw;
  act_t               sh;
  act_t               act;
  logic [PHASE_W-1:0] acc;
  logic               wrap0;
  logic               v0;
  logic               accept_c;
  logic [PHASE_W-1:0] phase_c;
  pipe_t              s1;
  pipe_t              dl [ROM_LAT];
  pipe_t              s2_in;
  logic [DATA_W-1:0]  dbl_c;
  logic [DATA_W-1:0]  raw_c;
  logic [DATA_W-1:0]  raw2;
  logic [AMP_W-1:0]   amp2;
  logic               wrap2;
  logic               v2;

  assign accept_c = tick & en;

  // Shadow config registers written by the control logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_fcw <= '0;
      sh     <= ACT_RST;
    end else if (cfg_load) begin
      sh_fcw <= cfg_fcw;
      sh     <= '{offset: cfg_offset, mode: cfg_mode, duty: cfg_duty, amp: cfg_amp};
    end
  end

  // Stage 0: accumulate; a tick promotes the shadow config to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      wrap0 <= 1'b0;
      v0    <= 1'b0;
      act   <= ACT_RST;
    end else if (phase_clr) begin
      acc   <= '0;
      wrap0 <= 1'b0;
      v0    <= 1'b0;
    end else if (accept_c) begin
      {wrap0, acc} <= {1'b0, acc} + {1'b0, sh_fcw};
      v0           <= 1'b1;
      act          <= sh;
    end else begin
      v0 <= 1'b0;
    end
  end

  assign phase_c = acc + act.offset;

  // Stage 1: ROM address and per-sample fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      s1       <= '0;
    end else if (v0) begin
      rom_addr <= ADDR_W'(phase_c >> (PHASE_W - ADDR_W));
      s1       <= '{valid: 1'b1, wrap: wrap0, mode: act.mode,
                    u: DATA_W'(phase_c >> (PHASE_W - DATA_W)),
                    duty: act.duty, amp: act.amp};
    end else begin
      s1.valid <= 1'b0;
    end
  end

  // Delay line aligning stage-1 fields with rom_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROM_LAT); i++) begin
        dl[i] <= '0;
      end
    end else begin
      dl[0] <= s1;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

  assign s2_in = dl[ROM_LAT-1];

  always_comb begin
    dbl_c = {s2_in.u[DATA_W-2:0], 1'b0};
    raw_c = s2_in.u;
    case (s2_in.mode)
      MODE_SINE:   raw_c = rom_q;
      MODE_SQUARE: raw_c = (s2_in.u < s2_in.duty) ? FULL_V : '0;
      MODE_TRI:    raw_c = s2_in.u[DATA_W-1] ? ~dbl_c : dbl_c;
      default:     raw_c = s2_in.u;
    endcase
  end

  // Stage 2: registered raw waveform sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw2  <= MID_V;
      amp2  <= '0;
      wrap2 <= 1'b0;
      v2    <= 1'b0;
    end else begin
      v2 <= s2_in.valid;
      if (s2_in.valid) begin
        raw2  <= raw_c;
        amp2  <= s2_in.amp;
        wrap2 <= s2_in.wrap;
      end
    end
  end

  dds_amp_scale #(
    .DATA_W (DATA_W),
    .AMP_W  (AMP_W)
  ) u_amp_scale (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (v2),
    .raw         (raw2),
    .amp         (amp2),
    .wrap        (wrap2),
    .value       (dac_value),
    .value_valid (dac_valid),
    .sync        (sync_out)
  );

endmodule
